multisim_push_serializer: RTL and testbench
===========================================

# multisim_push_serializer

Buffers wide transaction words from the simulated design and serializes each into RATIO beats of DATA_WIDTH bits for the server push stage directly downstream. It absorbs the multi-cycle back-pressure the push stage applies while its server is not ready, so the producer only stalls when the internal queue is full. Beats are emitted least-significant slice first, with a last-beat marker per word.

## Interface
- DATA_WIDTH, 64, width of one output beat; matches the downstream push stage's DATA_WIDTH.
- RATIO, 4, beats per input word (≥1); input width is RATIO*DATA_WIDTH.
- DEPTH, 4, queue depth in input words (power of two, ≥2).
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_vld  input  1  producer word valid.
- in_rdy  output  1  block can accept a word this cycle.
- in_data  input  RATIO*DATA_WIDTH  producer word.
- out_vld  output  1  beat available; drives push stage data_vld.
- out_rdy  input  1  push stage ready; driven from its data_rdy.
- out_data  output  DATA_WIDTH  current beat.
- out_last  output  1  current beat is the final slice of its word.
- level  output  $clog2(DEPTH+1)  words held, including the word being serialized.

## Operation
- Storage: DEPTH-entry circular queue of full-width words. Write and read pointers are $clog2(DEPTH) bits and wrap naturally. A separate count register (0..DEPTH) drives full and empty.
- Write: on in_vld && in_rdy, store in_data at the write pointer and increment the write pointer.
- in_rdy = !rst && (count != DEPTH).
  - No pass-through when full: a pop in the same cycle does not enable a write.
- Serialization state: beat counter beat_cnt, width max(1,$clog2(RATIO)).
  - out_vld = (count != 0).
  - out_data = head word bits [beat_cnt*DATA_WIDTH +: DATA_WIDTH].
  - out_last = (beat_cnt == RATIO-1); constant 1 when RATIO=1.
- Beat handshake (out_vld && out_rdy):
  - if !out_last: increment beat_cnt.
  - if out_last: clear beat_cnt to 0, increment the read pointer, and pop the word.
- Count update:
  - +1 on write only;
  - −1 on pop only;
  - unchanged on simultaneous write and pop (possible only when not full before the cycle).
- level = count.
- Stability: while out_vld=1 and out_rdy=0, out_vld, out_data and out_last hold their values. The push stage depends on this to re-send on its retry path.
- In_data is sampled only on handshake; in_data changes while in_rdy=0 are ignored.
- Reset:
  - pointers, count and beat_cnt go to 0; queue storage is not reset;
  - while rst=1: in_rdy=0, out_vld=0, out_last=(RATIO==1), level=0; out_data is don't-care;
  - a word partially serialized when reset asserts is discarded. After reset releases, no remaining beats of that word are emitted.

## Timing
- Input-to-output latency: a word written at edge N presents its first beat (out_vld=1) in the cycle after edge N, provided the queue was empty. There is no combinational in→out bypass.
- Throughput: one beat per cycle with out_rdy held high. A word occupies its slot for RATIO beat handshakes.
- Full-queue release: in_rdy rises the cycle after the pop edge (registered count).
- First cycle after rst deasserts: in_rdy=1, out_vld=0.
- out_rdy may toggle arbitrarily. No beat is lost or duplicated, and beat order is strictly word order, then slice 0..RATIO-1.

## Test plan
- Single word, RATIO=4, DATA_WIDTH=8, in_data=0x44332211, out_rdy=1:
  - out_data 0x11, 0x22, 0x33, 0x44 on four consecutive cycles starting one cycle after the write;
  - out_last only on 0x44;
  - level 1→0 after the fourth beat.
- Fill to full, out_rdy=0, DEPTH=4: in_rdy drops after the fourth write and level=4. A fifth in_vld is held, not accepted. Raise out_rdy: in_rdy returns the cycle after the first word's last beat.
- Random out_rdy stall pattern (50%) with back-to-back input words 0x0 .. 0xF (incrementing pattern per slice): the output beat stream equals the expected slice sequence exactly, and out_data/out_last are stable across every stall.
- Simultaneous write and pop at count=2: count stays 2 and the pointers advance correctly across wrap. Run 3×DEPTH words through to cover wrap-around.
- Reset mid-word: assert rst after 2 of 4 beats. Next cycle out_vld=0, in_rdy=0, level=0. After release, a new word's beats start at slice 0.
- RATIO=1: every beat has out_last=1, and words pass through one per cycle at full throughput.

Source files
------------

// File: rtl/multisim_push_serializer.sv
// Word-wide queue that serializes each stored word into RATIO beats, least-significant
// slice first, for the server push stage.
module multisim_push_serializer #(
    parameter int DATA_WIDTH = 64,
    parameter int RATIO      = 4,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic [RATIO*DATA_WIDTH-1:0]   in_data,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic [$clog2(DEPTH+1)-1:0]    level
);

    localparam int PW = $clog2(DEPTH);
    localparam int BW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL      = LW'(DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    logic [RATIO*DATA_WIDTH-1:0] mem [DEPTH];
    logic [RATIO-1:0][DATA_WIDTH-1:0] head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic [BW-1:0] beat_cnt;
    logic          push;
    logic          beat;
    logic          pop;

    // Handshakes are gated by reset so nothing leaks out while rst is held.
    assign in_rdy   = !rst && (count != FULL);
    assign out_vld  = !rst && (count != '0);
    assign out_last = (RATIO == 1) ? 1'b1 : (!rst && (beat_cnt == LAST_BEAT));
    assign level    = rst ? '0 : count;

    assign push = in_vld && in_rdy;
    assign beat = out_vld && out_rdy;
    assign pop  = beat && out_last;

    assign head = mem[rd_ptr];

    generate
        if (RATIO == 1) begin : g_single
            assign out_data = head[0];
        end else begin : g_multi
            assign out_data = head[beat_cnt];
        end
    endgenerate

    // Storage is not reset; only the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (beat) begin
                if (out_last) begin
                    beat_cnt <= '0;
                    rd_ptr   <= rd_ptr + 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multisim_push_serializer.sv
// Self-checking bench: directed and randomized traffic compared against a beat-queue model.
module tb_multisim_push_serializer;

    localparam int DW    = 8;
    localparam int RATIO = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_vld = 1'b0;
    logic                  in_rdy;
    logic [RATIO*DW-1:0]   in_data = '0;
    logic                  out_vld;
    logic                  out_rdy = 1'b0;
    logic [DW-1:0]         out_data;
    logic                  out_last;
    logic [LW-1:0]         level;

    logic                  in_vld1 = 1'b0;
    logic                  in_rdy1;
    logic [DW-1:0]         in_data1 = '0;
    logic                  out_vld1;
    logic                  out_rdy1 = 1'b0;
    logic [DW-1:0]         out_data1;
    logic                  out_last1;
    logic [LW-1:0]         level1;

    int checks = 0;
    int errors = 0;

    beat_t         q[$];
    int            word_cnt = 0;
    logic          stalled = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always #5 clk = ~clk;

    multisim_push_serializer #(.DATA_WIDTH(DW), .RATIO(RATIO), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
        .level(level)
    );

    multisim_push_serializer #(.DATA_WIDTH(DW), .RATIO(1), .DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rst(rst), .in_vld(in_vld1), .in_rdy(in_rdy1), .in_data(in_data1),
        .out_vld(out_vld1), .out_rdy(out_rdy1), .out_data(out_data1), .out_last(out_last1),
        .level(level1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RATIO*DW-1:0] word_of(input int w);
        logic [RATIO*DW-1:0] r;
        for (int k = 0; k < RATIO; k++) r[k*DW +: DW] = 8'(w * RATIO + k);
        return r;
    endfunction

    // One clock of traffic: drive, check at negedge against the model, advance the model at the edge.
    task automatic applyStimulus(input logic v, input logic [RATIO*DW-1:0] d, input logic r,
                                 output logic accepted);
        logic exp_rdy;
        logic exp_vld;
        beat_t b;
        in_vld  = v;
        in_data = d;
        out_rdy = r;
        @(negedge clk);
        exp_rdy = !rst && (word_cnt < DEPTH);
        exp_vld = !rst && (q.size() > 0);
        checkOutput("in_rdy", in_rdy, exp_rdy);
        checkOutput("out_vld", out_vld, exp_vld);
        checkOutput("level", level, rst ? 0 : word_cnt);
        if (rst) checkOutput("rst_last", out_last, 0);
        if (exp_vld) begin
            checkOutput("out_data", out_data, q[0].data);
            checkOutput("out_last", out_last, q[0].last);
        end
        if (stalled && !rst) begin
            checkOutput("stall_data", out_data, prev_data);
            checkOutput("stall_last", out_last, prev_last);
        end
        stalled   = exp_vld && !r;
        prev_data = out_data;
        prev_last = out_last;
        accepted  = v && exp_rdy;
        @(posedge clk);
        if (rst) begin
            q.delete();
            word_cnt = 0;
        end else begin
            if (exp_vld && r) begin
                b = q.pop_front();
                if (b.last) word_cnt--;
            end
            if (accepted) begin
                for (int k = 0; k < RATIO; k++) q.push_back({d[k*DW +: DW], k == RATIO - 1});
                word_cnt++;
            end
        end
        #1;
    endtask

    task automatic drain(input logic random_rdy);
        logic acc;
        int guard = 0;
        while (q.size() > 0 && guard < 500) begin
            applyStimulus(1'b0, '0, random_rdy ? 1'($urandom_range(0, 1)) : 1'b1, acc);
            guard++;
        end
        checkOutput("drain_bound", guard < 500, 1);
        checkOutput("drained_vld", out_vld, 0);
    endtask

    initial begin
        logic acc;
        int   w;
        int   guard;
        logic [DW-1:0] q1[$];

        $display("[TB] reset");
        applyStimulus(1'b0, '0, 1'b1, acc);
        applyStimulus(1'b0, '0, 1'b1, acc);
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b1, acc);

        $display("[TB] single word");
        applyStimulus(1'b1, 32'h44332211, 1'b1, acc);
        checkOutput("single_latency_vld", out_vld, 1);
        checkOutput("single_first_beat", out_data, 8'h11);
        drain(1'b0);

        $display("[TB] fill to full");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, word_of(20 + i), 1'b0, acc);
        checkOutput("full_level", level, 4);
        checkOutput("full_in_rdy", in_rdy, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, acc);
        checkOutput("release_in_rdy", in_rdy, 1);
        checkOutput("release_level", level, 3);
        drain(1'b0);

        $display("[TB] random stalls");
        w = 0;
        guard = 0;
        while (w < 16 && guard < 2000) begin
            applyStimulus(1'b1, word_of(w), 1'($urandom_range(0, 1)), acc);
            if (acc) w++;
            guard++;
        end
        checkOutput("rand_words", w, 16);
        drain(1'b1);

        $display("[TB] simultaneous write and pop");
        applyStimulus(1'b1, word_of(40), 1'b0, acc);
        applyStimulus(1'b1, word_of(41), 1'b0, acc);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, acc);
        applyStimulus(1'b1, word_of(42), 1'b1, acc);
        checkOutput("simul_level", level, 2);
        drain(1'b0);

        $display("[TB] wrap-around");
        w = 0;
        guard = 0;
        while (w < 3 * DEPTH && guard < 2000) begin
            applyStimulus(1'($urandom_range(0, 1)), word_of(50 + w), 1'($urandom_range(0, 3) != 0), acc);
            if (acc) w++;
            guard++;
        end
        checkOutput("wrap_words", w, 3 * DEPTH);
        drain(1'b1);

        $display("[TB] reset mid-word");
        applyStimulus(1'b1, 32'h88776655, 1'b0, acc);
        applyStimulus(1'b0, '0, 1'b1, acc);
        applyStimulus(1'b0, '0, 1'b1, acc);
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, acc);
        applyStimulus(1'b0, '0, 1'b1, acc);
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b1, acc);
        applyStimulus(1'b1, 32'hDDCCBBAA, 1'b1, acc);
        checkOutput("post_rst_slice0", out_data, 8'hAA);
        drain(1'b0);

        $display("[TB] RATIO=1 throughput");
        for (int i = 0; i < 20; i++) begin
            in_vld1  = 1'b1;
            in_data1 = 8'($urandom);
            out_rdy1 = 1'b1;
            @(negedge clk);
            checkOutput("r1_in_rdy", in_rdy1, 1);
            checkOutput("r1_out_vld", out_vld1, q1.size() != 0);
            checkOutput("r1_out_last", out_last1, 1);
            checkOutput("r1_level", level1, q1.size());
            if (q1.size() != 0) checkOutput("r1_out_data", out_data1, q1[0]);
            @(posedge clk);
            if (q1.size() != 0) void'(q1.pop_front());
            q1.push_back(in_data1);
            #1;
        end
        in_vld1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
